// File: rtl/seq_alu_pkg.sv
// Shared types and opcode helpers for the multi-cycle ALU (seq_alu).
package seq_alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    LSL = 4'd1,
    LSR = 4'd2,
    XOR = 4'd3,
    SNE = 4'd4,
    MOV = 4'd5,
    SEQ = 4'd6,
    MSK = 4'd7,
    ASR = 4'd8,
    ROL = 4'd9,
    ROR = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } seq_alu_state_t;

  // Fill source for the vacated bit of a single-position shift.
  localparam logic [1:0] FILL_ZERO = 2'd0;
  localparam logic [1:0] FILL_SIGN = 2'd1;
  localparam logic [1:0] FILL_ROT  = 2'd2;

  function automatic logic is_iterative(alu_op_t op);
    return op inside {LSL, LSR, ASR, ROL, ROR, MSK};
  endfunction

  function automatic logic shift_right(alu_op_t op);
    return op inside {LSR, ASR, ROR};
  endfunction

  function automatic logic [1:0] shift_fill(alu_op_t op);
    case (op)
      ASR:      return FILL_SIGN;
      ROL, ROR: return FILL_ROT;
      default:  return FILL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/seq_alu_shift_step.sv
// Single-position shift/rotate: one step of the iterative datapath and
// one link of the barrel chain.
module alu_shift_step
  import seq_alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         i_right,
  input  logic [1:0]   i_fill,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val_c,
  output logic         o_bit_c
);

  logic w_fill_bit;

  always_comb begin
    w_fill_bit = 1'b0;
    if (i_right) begin
      o_bit_c = i_val[0];
      if (i_fill == FILL_ROT)       w_fill_bit = i_val[0];
      else if (i_fill == FILL_SIGN) w_fill_bit = i_val[W-1];
      o_val_c = {w_fill_bit, i_val[W-1:1]};
    end else begin
      o_bit_c = i_val[W-1];
      if (i_fill == FILL_ROT) w_fill_bit = i_val[W-1];
      o_val_c = {i_val[W-2:0], w_fill_bit};
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with Start/Done handshake and registered result/flags.
// Define BARREL_SHIFT_EN to compute all shifts in a single cycle.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 3,
  parameter int unsigned IW = 5
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [3:0]    OP,
  input  logic [W-1:0]  InputA,
  input  logic [W-1:0]  InputB,
  input  logic [AW-1:0] Amt,
  input  logic [IW-1:0] Immediate,
  input  logic          SC_in,
  output logic          Busy,
  output logic          Done,
  output logic [W-1:0]  Out,
  output logic          Zero,
  output logic          Parity,
  output logic          Odd,
  output logic          Carry,
  output logic          Illegal
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned W1 = W + 1;

  seq_alu_state_t r_state;
  alu_op_t        r_op;
  logic [W-1:0]   r_val;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_out;
  logic           r_zero, r_parity, r_odd, r_carry, r_illegal, r_busy, r_done;

  alu_op_t        w_op;
  logic [W-1:0]   w_imm, w_init, w_res, w_step_val;
  logic [CW-1:0]  w_amt;
  logic           w_msk_oob, w_step_bit, w_load, w_iter, w_carry, w_illegal;

  assign w_op      = alu_op_t'(OP);
  assign w_imm     = W'(Immediate);
  assign w_init    = (w_op == MSK) ? W'(1) : InputA;
  assign w_msk_oob = (InputB >= W'(W));

  // Effective step count; shift amounts beyond W saturate at W steps.
  always_comb begin
    if (w_op == MSK)         w_amt = CW'(InputB);
    else if (32'(Amt) >= W)  w_amt = CW'(W);
    else                     w_amt = CW'(Amt);
  end

  alu_shift_step #(.W(W)) u_step (
    .i_right (shift_right(r_op)),
    .i_fill  (shift_fill(r_op)),
    .i_val   (r_val),
    .o_val_c (w_step_val),
    .o_bit_c (w_step_bit)
  );

`ifdef BARREL_SHIFT_EN
  logic [W-1:0] w_bar_val;
  logic         w_bar_bit;

  // W chained steps; stage i is bypassed once i reaches the step count.
  for (genvar i = 0; i < W; i++) begin : g_bar
    logic [W-1:0] w_in, w_sv, w_out;
    logic         w_cin, w_sb, w_cout;
    if (i == 0) begin : g_head
      assign w_in  = w_init;
      assign w_cin = 1'b0;
    end else begin : g_link
      assign w_in  = g_bar[i-1].w_out;
      assign w_cin = g_bar[i-1].w_cout;
    end
    alu_shift_step #(.W(W)) u_bstep (
      .i_right (shift_right(w_op)),
      .i_fill  (shift_fill(w_op)),
      .i_val   (w_in),
      .o_val_c (w_sv),
      .o_bit_c (w_sb)
    );
    assign w_out  = (CW'(i) < w_amt) ? w_sv : w_in;
    assign w_cout = (CW'(i) < w_amt) ? w_sb : w_cin;
  end

  assign w_bar_val = g_bar[W-1].w_out;
  assign w_bar_bit = g_bar[W-1].w_cout;
`endif

  // Result decode: w_load writes Out/flags this edge, w_iter enters ITER.
  always_comb begin
    w_load    = 1'b0;
    w_iter    = 1'b0;
    w_res     = '0;
    w_carry   = 1'b0;
    w_illegal = 1'b0;
    if (r_state == IDLE && Start) begin
      w_load = 1'b1;
      if (is_iterative(w_op)) begin
        if (w_op == MSK && w_msk_oob) w_res = '0;
`ifdef BARREL_SHIFT_EN
        else begin
          w_res   = w_bar_val;
          w_carry = w_bar_bit;
        end
`else
        else if (w_amt == '0) w_res = w_init;
        else begin
          w_load = 1'b0;
          w_iter = 1'b1;
        end
`endif
      end else begin
        case (w_op)
          ADD:     {w_carry, w_res} = W1'(InputA) + W1'(InputB) + W1'(SC_in);
          XOR:     w_res = InputA ^ InputB;
          MOV:     w_res = InputB;
          SEQ:     w_res = W'(InputA == w_imm);
          SNE:     w_res = W'(InputA != w_imm);
          default: w_illegal = 1'b1;
        endcase
      end
    end else if (r_state == ITER && r_cnt == CW'(1)) begin
      w_load  = 1'b1;
      w_res   = w_step_val;
      w_carry = w_step_bit;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= IDLE;
      r_op      <= ADD;
      r_val     <= '0;
      r_cnt     <= '0;
      r_out     <= '0;
      r_zero    <= 1'b1;
      r_parity  <= 1'b0;
      r_odd     <= 1'b0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_load) begin
        r_out     <= w_res;
        r_zero    <= ~|w_res;
        r_parity  <= ^w_res;
        r_odd     <= w_res[0];
        r_carry   <= w_carry;
        r_illegal <= w_illegal;
      end
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_load) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (w_iter) begin
            r_state <= ITER;
            r_busy  <= 1'b1;
            r_op    <= w_op;
            r_val   <= w_init;
            r_cnt   <= w_amt;
          end
        end
        ITER: begin
          r_val <= w_step_val;
          r_cnt <= r_cnt - CW'(1);
          if (w_load) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Busy    = r_busy;
  assign Done    = r_done;
  assign Out     = r_out;
  assign Zero    = r_zero;
  assign Parity  = r_parity;
  assign Odd     = r_odd;
  assign Carry   = r_carry;
  assign Illegal = r_illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed bench for seq_alu against a behavioural model.
module tb_seq_alu;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] op = '0;
  logic [7:0] ina = '0, inb = '0;
  logic [2:0] amt = '0;
  logic [4:0] imm = '0;
  logic       sc_in = 1'b0;
  logic       busy, done, zero, parity, odd, carry, illegal;
  logic [7:0] out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_alu dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .OP(op),
    .InputA(ina), .InputB(inb), .Amt(amt), .Immediate(imm), .SC_in(sc_in),
    .Busy(busy), .Done(done), .Out(out), .Zero(zero), .Parity(parity),
    .Odd(odd), .Carry(carry), .Illegal(illegal)
  );

  // Expected result, carry, illegal flag and Start-to-Done latency.
  function automatic void ref_model(input int o, input int a, input int b, input int n_in,
                                    input int im, input int sc, output int r, output int c,
                                    output int il, output int lat);
    int n, sa;
    r = 0; c = 0; il = 0; lat = 1;
    n = (n_in > W) ? W : n_in;
    sa = (a >= 128) ? a - 256 : a;
    case (o)
      0: begin r = (a + b + sc) % 256; c = (a + b + sc) / 256; end
      1: if (n > 0) begin r = (a << n) & 255; c = (a >> (W - n)) & 1; lat = 1 + n; end else r = a;
      2: if (n > 0) begin r = a >> n; c = (a >> (n - 1)) & 1; lat = 1 + n; end else r = a;
      3: r = a ^ b;
      4: r = (a != im) ? 1 : 0;
      5: r = b;
      6: r = (a == im) ? 1 : 0;
      7: if (b < W) begin r = 1 << b; lat = 1 + b; end
      8: if (n > 0) begin r = (sa >>> n) & 255; c = (a >> (n - 1)) & 1; lat = 1 + n; end else r = a;
      9: if (n > 0) begin r = ((a << n) | (a >> (W - n))) & 255; c = r & 1; lat = 1 + n; end else r = a;
      10: if (n > 0) begin r = ((a >> n) | (a << (W - n))) & 255; c = (r >> 7) & 1; lat = 1 + n; end else r = a;
      default: il = 1;
    endcase
`ifdef BARREL_SHIFT_EN
    lat = 1;
`endif
  endfunction

  task automatic run_op(input string tag, input int o, input int a, input int b,
                        input int n, input int im, input int sc);
    int er, ec, eil, elat, cyc;
    logic busy_ok;
    logic [7:0] eo;
    logic [4:0] ef;
    ref_model(o, a, b, n, im, sc, er, ec, eil, elat);
    eo = 8'(er);
    ef = {1'(ec), (eo == 8'h00), ^eo, eo[0], 1'(eil)};
    @(negedge clk);
    op = 4'(o); ina = 8'(a); inb = 8'(b); amt = 3'(n); imm = 5'(im); sc_in = 1'(sc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 4'($urandom); ina = 8'($urandom); inb = 8'($urandom);
    amt = 3'($urandom); imm = 5'($urandom); sc_in = 1'($urandom);
    cyc = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc <= 20) begin
      if (busy !== 1'(cyc < elat)) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
    checks++;
    if (cyc != elat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", tag, cyc, elat);
    end
    checks++;
    if (busy_ok !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: Busy profile wrong, expected high for %0d cycles", tag, elat - 1);
    end
    checks++;
    if (out !== eo) begin
      errors++;
      $display("FAIL %s out: got %02h expected %02h", tag, out, eo);
    end
    checks++;
    if ({carry, zero, parity, odd, illegal} !== ef) begin
      errors++;
      $display("FAIL %s flags(C,Z,P,O,I): got %05b expected %05b", tag,
               {carry, zero, parity, odd, illegal}, ef);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got %b expected 0", tag, done);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (out !== 8'h00) begin
      errors++;
      $display("FAIL %s out: got %02h expected 00", tag, out);
    end
    checks++;
    if ({carry, zero, parity, odd, illegal} !== 5'b01000) begin
      errors++;
      $display("FAIL %s flags(C,Z,P,O,I): got %05b expected 01000", tag,
               {carry, zero, parity, odd, illegal});
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL %s busy/done: got %02b expected 00", tag, {busy, done});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    run_op("add", 0, 8'hF0, 8'h20, 0, 0, 1);
    run_op("add_nc", 0, 8'h12, 8'h34, 0, 0, 0);
    run_op("xor", 3, 8'hA5, 8'h0F, 0, 0, 0);
    run_op("mov", 5, 8'h00, 8'h7E, 0, 0, 0);
    run_op("seq", 6, 8'h15, 0, 0, 5'h15, 0);
    run_op("sne", 4, 8'h15, 0, 0, 5'h15, 0);
    run_op("seq_ne", 6, 8'h35, 0, 0, 5'h15, 0);
    run_op("illegal", 15, 8'h55, 8'h66, 0, 0, 0);
    run_op("mov_clr", 5, 8'h00, 8'h81, 0, 0, 0);
  endtask

  task automatic test_iterative;
    run_op("lsl", 1, 8'h81, 0, 3, 0, 0);
    run_op("rol", 9, 8'h81, 0, 3, 0, 0);
    run_op("asr", 8, 8'h80, 0, 7, 0, 0);
    run_op("lsr", 2, 8'h81, 0, 1, 0, 0);
    run_op("ror", 10, 8'h03, 0, 2, 0, 0);
    run_op("lsl0", 1, 8'hC3, 0, 0, 0, 0);
    run_op("msk6", 7, 8'h00, 6, 0, 0, 0);
    run_op("msk0", 7, 8'h00, 0, 0, 0, 0);
    run_op("msk9", 7, 8'h00, 9, 0, 0, 0);
  endtask

  task automatic test_start_ignored;
    int er, ec, eil, elat, ndone, pulse_cyc;
    ref_model(1, 8'h81, 0, 5, 0, 0, er, ec, eil, elat);
`ifdef BARREL_SHIFT_EN
    pulse_cyc = 1;
`else
    pulse_cyc = 2;
`endif
    @(negedge clk);
    op = 4'd1; ina = 8'h81; amt = 3'd5; start = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      start = 1'b0;
      if (c == pulse_cyc) begin
        start = 1'b1; op = 4'd5; inb = 8'h33;
      end else if (done === 1'b1) begin
        start = 1'b1;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL ignore_start done_count: got %0d expected 1", ndone);
    end
    checks++;
    if (out !== 8'(er)) begin
      errors++;
      $display("FAIL ignore_start out: got %02h expected %02h", out, 8'(er));
    end
  endtask

  task automatic test_reset_abort;
    int nd;
    run_op("pre_abort", 5, 0, 8'hA5, 0, 0, 0);
    @(negedge clk);
    op = 4'd1; ina = 8'h81; amt = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL abort no_done: got %0d Done pulses expected 0", nd);
    end
    run_op("post_abort", 1, 8'h81, 0, 3, 0, 0);
  endtask

  task automatic test_random;
    int o, a, b, n, im;
    for (int i = 0; i < 80; i++) begin
      o  = ($urandom_range(0, 15) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
      a  = $urandom_range(0, 255);
      b  = (o == 7) ? $urandom_range(0, 12) : $urandom_range(0, 255);
      n  = $urandom_range(0, 7);
      im = $urandom_range(0, 31);
      if ((o == 4 || o == 6) && $urandom_range(0, 1) == 1) a = im;
      run_op("rand", o, a, b, n, im, $urandom_range(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_iterative();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle successor to the processor's combinational ALU. It adds a Start/Done handshake, registered result and flags, carry in/out, and rotate/arithmetic-shift modes. Shifts and masks run iteratively, one bit position per cycle, to keep the datapath small. It sits between the register file and writeback; the control FSM stalls the PC while Busy is high.

Parameters:
W, 8, data width (must be at least 4)
AW, 3, width of the shift/loop amount input
IW, 5, width of the compare immediate

Ports:
Clk  input  1  clock, rising-edge
Reset_n  input  1  asynchronous active-low reset
Start  input  1  request pulse; sampled only in IDLE
OP  input  4  opcode, type alu_op_t from the package
InputA  input  W  operand A
InputB  input  W  operand B; also the MSK bit index
Amt  input  AW  shift/rotate amount
Immediate  input  IW  compare immediate, zero-extended to W
SC_in  input  1  carry in for ADD
Busy  output  1  high from the cycle after Start is accepted until Done
Done  output  1  one-cycle pulse; Out and flags valid from this cycle
Out  output  W  registered result
Zero  output  1  registered, ~|Out
Parity  output  1  registered, ^Out
Odd  output  1  registered, Out[0]
Carry  output  1  registered; ADD carry out, or last bit shifted out
Illegal  output  1  registered; opcode not decoded

Behaviour:
- Reset (async, Reset_n=0): state IDLE; Out=0, Zero=1, Parity=0, Odd=0, Carry=0, Illegal=0, Busy=0, Done=0.
- Operands and OP are latched on Start in IDLE. Start while Busy or Done is ignored (no queueing).
- States:
  - IDLE: on Start with a single-cycle op, go to DONE. On Start with an iterative op, go to ITER with count = effective amount.
  - ITER: shift one position per cycle; decrement count; go to DONE when count reaches 0.
  - DONE: assert Done for one cycle with Out and flags updated; then return to IDLE.
- Single-cycle ops, latency 1 (Done in the cycle after Start):
  - ADD: {Carry,Out} = A + B + SC_in.
  - XOR: Out = A ^ B.
  - MOV: Out = B.
  - SEQ / SNE: Out = 1 if A ==/!= zext(Immediate), else 0.
  - Illegal opcode: Out = 0, Illegal = 1.
- Iterative ops, latency = 1 + amount (effective amount 0 gives latency 1):
  - LSL / LSR: zero fill. Carry = last bit shifted out; Carry = 0 if amount is 0.
  - ASR: sign fill.
  - ROL / ROR: bit wraps around; Carry = last bit moved.
  - MSK: Out = 1 << B. If B >= W, Out = 0 with latency 1. Otherwise the latency is 1 + B.
- Amount is taken modulo nothing. Amt >= W on LSL/LSR gives Out = 0; on ASR gives all sign bits. The count is clamped to W cycles, so worst-case latency is W+1.
- Flags are computed from the final Out in the same edge that Out is written. Flags and Out hold their values until the next Done.
- Illegal is cleared on every legal Done.
- Reset asserted mid-ITER aborts the operation: no Done, and all outputs return to reset values.

Optional Feature:
BARREL_SHIFT_EN
- Defined: LSL/LSR/ASR/ROL/ROR/MSK are computed combinationally. Every op has latency 1 and ITER is never entered.
- Undefined: iterative behaviour as described above.
- Out, flags and Done are identical either way except for timing.

Decomposition:
- Package Definitions holds:
  - alu_op_t, a 4-bit enum: ADD=0, LSL=1, LSR=2, XOR=3, SNE=4, MOV=5, SEQ=6, MSK=7, ASR=8, ROL=9, ROR=10.
  - seq_alu_state_t: IDLE, ITER, DONE.
  - function is_iterative(alu_op_t).
- One sub-module, alu_shift_step: combinational single-position shift/rotate taking direction, fill mode and current value; returns the next value and the shifted-out bit. It is reused by the barrel path as a chained loop.

Test Plan:
- W=8, ADD A=8'hF0, B=8'h20, SC_in=1 -> Done the next cycle; Out=8'h11, Carry=1, Zero=0, Parity=0, Odd=1.
- LSL A=8'h81, Amt=3 -> Busy for 3 cycles, Done at cycle 4; Out=8'h08, Carry=0. Repeat with ROL: Out=8'h0C, Carry=0.
- ASR A=8'h80, Amt=7 -> Out=8'hFF, latency 8. MSK B=6 -> Out=8'h40. MSK B=9 -> Out=0, Zero=1, latency 1.
- SEQ A=8'h15, Immediate=5'h15 -> Out=1. SNE with the same operands -> Out=0, Zero=1. OP=4'hF -> Out=0, Illegal=1; a following MOV clears Illegal.
- Start pulsed again during ITER -> ignored and exactly one Done. Reset_n low at cycle 2 of an Amt=5 shift -> no Done, outputs at reset values, and the next Start operates normally.
- Run the same op set with BARREL_SHIFT_EN defined -> identical Out/flags, all latencies 1.
